// File: rtl/ad_ip_jesd204_tpl_dac_pngen.sv
// ---------------------------------------------------------------------------
// ad_ip_jesd204_tpl_dac_pngen
//
// PN9 / PN23 test-pattern generator for one DAC converter channel. Emits one
// sample word per clock. The bit order, polarity and polynomials match the
// ADC-side PN monitor, so a DAC->ADC or JESD link loopback can be qualified
// end to end.
//
// Parameters
//   CONVERTER_RESOLUTION  bits per sample (R)
//   DATA_PATH_WIDTH       samples per clock (S); word width N = R*S
//   TWOS_COMPLEMENT       1 = two's complement, 0 = offset binary
//
// Ports
//   clk         converter-rate clock
//   reset       synchronous, active-high
//   enable      1 = advance sequence and drive PN data, 0 = hold and midscale
//   pn_seq_sel  0 = PN9 (x^9+x^5+1), any other value = PN23 (x^23+x^18+1)
//   err_inject  flip data bit 0 of the word registered in this enabled cycle
//   data        N-bit sample word, sample i at data[i*R +: R], i=0 oldest
//   data_valid  1 when data carries PN content
// ---------------------------------------------------------------------------
module ad_ip_jesd204_tpl_dac_pngen #(
  parameter int CONVERTER_RESOLUTION = 16,
  parameter int DATA_PATH_WIDTH      = 1,
  parameter bit TWOS_COMPLEMENT      = 1'b1
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              enable,
  input  logic [3:0]                                        pn_seq_sel,
  input  logic                                              err_inject,
  output logic [CONVERTER_RESOLUTION*DATA_PATH_WIDTH-1:0]   data,
  output logic                                              data_valid
);

  localparam int R = CONVERTER_RESOLUTION;
  localparam int S = DATA_PATH_WIDTH;
  localparam int N = R * S;
  localparam logic [22:0] SEED = '1;

  // History keeps the last 23 emitted bits, newest bit in position 0.
  logic [22:0]  history_q;
  logic         pn23_q;
  logic         sel_pn23;
  logic         seq_change;
  logic [22:0]  shift_v;
  logic [22:0]  next_history;
  logic [N-1:0] pn_word;
  logic [N-1:0] mapped;
  logic [N-1:0] midscale;
  logic [N-1:0] err_mask;

  assign sel_pn23   = |pn_seq_sel;
  assign seq_change = sel_pn23 != pn23_q;

  // Parallel unroll of the serial recurrence. Each step looks back into the
  // running shift value, so the loop is valid for any N, including N < 23.
  // A polynomial change starts the computation from the seed so the word
  // registered in that same cycle is already the new sequence's first word.
  always_comb begin
    shift_v = seq_change ? SEED : history_q;
    pn_word = '0;
    for (int j = 0; j < N; j++) begin
      logic fb;
      fb = sel_pn23 ? (shift_v[22] ^ shift_v[17]) : (shift_v[8] ^ shift_v[4]);
      pn_word[N-1-j] = fb;
      shift_v = {shift_v[21:0], fb};
    end
    next_history = shift_v;
  end

  // The oldest R bits of the word land in sample 0. Offset binary is the
  // two's complement value with each sample MSB flipped, which also defines
  // midscale as only the sample MSBs set.
  always_comb begin
    mapped   = '0;
    midscale = '0;
    for (int i = 0; i < S; i++) begin
      mapped[i*R +: R] = pn_word[(S-1-i)*R +: R];
      if (!TWOS_COMPLEMENT) begin
        mapped[i*R + R - 1] = ~pn_word[(S-1-i)*R + R - 1];
      end
      midscale[i*R + R - 1] = ~TWOS_COMPLEMENT;
    end
    err_mask    = '0;
    err_mask[0] = err_inject;
  end

  // Output and history registers. The decoded selection is tracked every
  // cycle so that a change seen while disabled still reloads the seed.
  // The error mask only touches the output, never the history, so the
  // following word is unaffected.
  always_ff @(posedge clk) begin
    if (reset) begin
      history_q  <= SEED;
      pn23_q     <= 1'b0;
      data       <= midscale;
      data_valid <= 1'b0;
    end else begin
      pn23_q <= sel_pn23;
      if (enable) begin
        history_q  <= next_history;
        data       <= mapped ^ err_mask;
        data_valid <= 1'b1;
      end else begin
        history_q  <= seq_change ? SEED : history_q;
        data       <= midscale;
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_pngen.sv
// ---------------------------------------------------------------------------
// tb_ad_ip_jesd204_tpl_dac_pngen
//
// Drives two generator instances from the same controls: a 16-bit single
// sample two's complement channel and a 16-bit dual-sample offset binary
// channel. Expected words come from precomputed serial PN bit streams and a
// per-instance bit position, plus a table of hand-derived words.
// ---------------------------------------------------------------------------
module tb_ad_ip_jesd204_tpl_dac_pngen;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  pn_seq_sel;
  logic        err_inject;
  logic [15:0] data1;
  logic        valid1;
  logic [31:0] data2;
  logic        valid2;

  int nVec = 0;
  int nErr = 0;

  // Serial reference streams, bit k is the k-th bit after the all-ones seed.
  bit pn9Bits[511];
  bit pn23Bits[];

  // Model state: decoded polynomial and bits consumed per instance.
  bit          mPn23;
  int          mPos1;
  int          mPos2;
  logic [31:0] expData1;
  logic        expValid1;
  logic [31:0] expData2;
  logic        expValid2;

  typedef struct {
    bit          r;
    bit          en;
    logic [3:0]  sel;
    bit          err;
    logic [15:0] expData;
    bit          expValid;
  } vec_t;

  vec_t tbl[13];
  logic [15:0] periodWords[512];

  // Free-running clock.
  always #5 clk = ~clk;

  ad_ip_jesd204_tpl_dac_pngen #(
    .CONVERTER_RESOLUTION(16),
    .DATA_PATH_WIDTH(1),
    .TWOS_COMPLEMENT(1'b1)
  ) dut1 (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .pn_seq_sel(pn_seq_sel),
    .err_inject(err_inject),
    .data(data1),
    .data_valid(valid1)
  );

  ad_ip_jesd204_tpl_dac_pngen #(
    .CONVERTER_RESOLUTION(16),
    .DATA_PATH_WIDTH(2),
    .TWOS_COMPLEMENT(1'b0)
  ) dut2 (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .pn_seq_sel(pn_seq_sel),
    .err_inject(err_inject),
    .data(data2),
    .data_valid(valid2)
  );

  function automatic bit seqBit(bit p23, int k);
    return p23 ? pn23Bits[k] : pn9Bits[k % 511];
  endfunction

  // Sample i is the i-th group of 16 bits in time order, earliest bit as MSB.
  function automatic logic [31:0] expWord(bit p23, int pos, int s, bit tc, bit err);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < s; i++) begin
      for (int b = 0; b < 16; b++) begin
        w[i*16 + 15 - b] = seqBit(p23, pos + i*16 + b);
      end
      if (!tc) w[i*16 + 15] = ~w[i*16 + 15];
    end
    w[0] = w[0] ^ err;
    return w;
  endfunction

  function automatic logic [31:0] midWord(int s, bit tc);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < s; i++) begin
      if (!tc) w[i*16 + 15] = 1'b1;
    end
    return w;
  endfunction

  // Compare one observed {valid, data} pair with its expectation.
  task automatic checkOutput(input string name, input logic [31:0] actData, input logic actValid,
                             input logic [31:0] reqData, input logic reqValid);
    nVec++;
    if (actData !== reqData || actValid !== reqValid) begin
      nErr++;
      $display("[TB] FAIL %s: got data=%h valid=%b, expected data=%h valid=%b",
               name, actData, actValid, reqData, reqValid);
    end
  endtask

  // Apply one cycle of controls, then advance the model for that edge.
  task automatic applyStimulus(input bit r, input bit en, input logic [3:0] sel, input bit err);
    bit p;
    reset      = r;
    enable     = en;
    pn_seq_sel = sel;
    err_inject = err;
    @(posedge clk);
    #1;
    if (r) begin
      mPn23 = 1'b0;
      mPos1 = 0;
      mPos2 = 0;
      expData1 = midWord(1, 1'b1);  expValid1 = 1'b0;
      expData2 = midWord(2, 1'b0);  expValid2 = 1'b0;
    end else begin
      p = |sel;
      if (p != mPn23) begin
        mPos1 = 0;
        mPos2 = 0;
        mPn23 = p;
      end
      if (en) begin
        expData1 = expWord(p, mPos1, 1, 1'b1, err);  expValid1 = 1'b1;
        expData2 = expWord(p, mPos2, 2, 1'b0, err);  expValid2 = 1'b1;
        mPos1 += 16;
        mPos2 += 32;
      end else begin
        expData1 = midWord(1, 1'b1);  expValid1 = 1'b0;
        expData2 = midWord(2, 1'b0);  expValid2 = 1'b0;
      end
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_s1"}, {16'h0, data1}, valid1, expData1, expValid1);
    checkOutput({tag, "_s2"}, data2, valid2, expData2, expValid2);
  endtask

  // Main sequence: build reference streams, run the hand-derived table,
  // the PN9 period check, then a randomized run against the model.
  initial begin
    int dupCount;
    logic [3:0] curSel;

    for (int k = 0; k < 511; k++) begin
      bit a, b;
      a = (k < 9) ? 1'b1 : pn9Bits[k-9];
      b = (k < 5) ? 1'b1 : pn9Bits[k-5];
      pn9Bits[k] = a ^ b;
    end
    pn23Bits = new[200000];
    for (int k = 0; k < 200000; k++) begin
      bit a, b;
      a = (k < 23) ? 1'b1 : pn23Bits[k-23];
      b = (k < 18) ? 1'b1 : pn23Bits[k-18];
      pn23Bits[k] = a ^ b;
    end

    tbl[0]  = '{1'b1, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 4'd0, 1'b0, 16'h07BE, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 4'd0, 1'b0, 16'h2E64, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 4'd0, 1'b1, 16'h0000, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 4'd0, 1'b1, 16'h129C, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 4'd0, 1'b0, 16'hA3CF, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 4'd1, 1'b0, 16'h0000, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 4'd5, 1'b0, 16'h3E00, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 4'd5, 1'b0, 16'h0000, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 4'd5, 1'b0, 16'h0000, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 4'd5, 1'b0, 16'h3E00, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 4'd0, 1'b0, 16'h07BE, 1'b1};

    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    checkModel("reset");

    for (int i = 0; i < 13; i++) begin
      applyStimulus(tbl[i].r, tbl[i].en, tbl[i].sel, tbl[i].err);
      checkOutput($sformatf("table%0d", i), {16'h0, data1}, valid1,
                  {16'h0, tbl[i].expData}, tbl[i].expValid);
      checkModel($sformatf("table%0d_model", i));
    end

    // PN9 period: 511 bits per period with 16-bit words means word 511
    // lands back on bit 0 of the sequence.
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    for (int i = 0; i < 512; i++) begin
      applyStimulus(1'b0, 1'b1, 4'd0, 1'b0);
      periodWords[i] = data1;
      if (i == 0) begin
        checkOutput("dual_first", data2, valid2, 32'hAE64_87BE, 1'b1);
      end
    end
    checkOutput("period_first", {16'h0, periodWords[0]}, 1'b1, 32'h0000_07BE, 1'b1);
    checkOutput("period_wrap", {16'h0, periodWords[511]}, 1'b1, 32'h0000_07BE, 1'b1);
    dupCount = 0;
    for (int k = 1; k < 511; k++) begin
      if (periodWords[k] == periodWords[0] && periodWords[k+1] == periodWords[1]) dupCount++;
    end
    checkOutput("period_unique", dupCount, 1'b1, 32'd0, 1'b1);

    // Randomized run: mostly enabled, occasional selection changes,
    // error pulses and resets.
    curSel = 4'd0;
    for (int i = 0; i < 2000; i++) begin
      bit r, en, err;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 4))
          0, 1:    curSel = 4'd0;
          2:       curSel = 4'd1;
          3:       curSel = 4'd5;
          default: curSel = 4'hF;
        endcase
      end
      r   = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 3) != 0);
      err = ($urandom_range(0, 9) == 0);
      applyStimulus(r, en, curSel, err);
      checkModel("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
